// File: rtl/border_update.sv
// border_update: folds the four cells of a locked piece into the per-column
// stack heights, then presents the merged border and pulses write_mem so the
// column-border register bank can load it.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       merge request, honoured only in IDLE
//   rho_x/rho_y packed coordinates of the four piece cells (cell 0 in the MSBs)
//   cur_border  current register-bank contents (column 0 in the MSBs)
//   new_border  merged border, same packing as cur_border
//   write_mem   one-cycle load strobe for the register bank
//   busy        high while an operation is in flight
//   done        one-cycle completion pulse
//   game_over   sticky flag: the stack reached the top row
//   bad_cell    last operation had an x coordinate outside the playfield
module border_update #(
    parameter int unsigned MEM_WIDTH  = 10,
    parameter int unsigned MEM_HEIGHT = 20,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [4*WIDTH-1:0]           rho_x,
    input  logic [4*WIDTH-1:0]           rho_y,
    input  logic [MEM_WIDTH*WIDTH-1:0]   cur_border,
    output logic [MEM_WIDTH*WIDTH-1:0]   new_border,
    output logic                         write_mem,
    output logic                         busy,
    output logic                         done,
    output logic                         game_over,
    output logic                         bad_cell
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                   state, state_next;
    logic [1:0]                   idx, idx_next;
    logic [4*WIDTH-1:0]           rho_x_q, rho_y_q;
    logic [MEM_WIDTH*WIDTH-1:0]   border_next;
    logic                         bad_next, go_next, load;
    logic [WIDTH-1:0]             cell_x, cell_y, h_clamp;
    logic [WIDTH:0]               h_full;
    logic                         cell_ok;

    // Next-state, cell selection and column merge for the current cell
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        border_next = new_border;
        bad_next    = bad_cell;
        go_next     = game_over;
        load        = 1'b0;
        cell_x      = '0;
        cell_y      = '0;

        for (int k = 0; k < 4; k++) begin
            if (idx == 2'(k)) begin
                cell_x = rho_x_q[WIDTH*(3-k) +: WIDTH];
                cell_y = rho_y_q[WIDTH*(3-k) +: WIDTH];
            end
        end

        // One extra bit so y = 2^WIDTH-1 cannot wrap to a height of 0
        h_full  = {1'b0, cell_y} + (WIDTH+1)'(1);
        h_clamp = (h_full > (WIDTH+1)'(MEM_HEIGHT)) ? WIDTH'(MEM_HEIGHT)
                                                    : h_full[WIDTH-1:0];
        cell_ok = (cell_x < WIDTH'(MEM_WIDTH));

        case (state)
            IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    border_next = cur_border;
                    bad_next    = 1'b0;
                    idx_next    = 2'd0;
                    state_next  = SCAN;
                end
            end
            SCAN: begin
                if (!cell_ok) begin
                    bad_next = 1'b1;
                end else begin
                    // Compare against the working copy so repeated columns keep the max
                    for (int i = 0; i < int'(MEM_WIDTH); i++) begin
                        if ((cell_x == WIDTH'(i)) &&
                            (new_border[WIDTH*(MEM_WIDTH-1-i) +: WIDTH] < h_clamp)) begin
                            border_next[WIDTH*(MEM_WIDTH-1-i) +: WIDTH] = h_clamp;
                        end
                    end
                    if (h_full >= (WIDTH+1)'(MEM_HEIGHT)) begin
                        go_next = 1'b1;
                    end
                end
                idx_next = idx + 2'd1;
                if (idx == 2'd3) begin
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            rho_x_q    <= '0;
            rho_y_q    <= '0;
            new_border <= '0;
            bad_cell   <= 1'b0;
            game_over  <= 1'b0;
            write_mem  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            new_border <= border_next;
            bad_cell   <= bad_next;
            game_over  <= go_next;
            write_mem  <= (state_next == WRITE);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
            if (load) begin
                rho_x_q <= rho_x;
                rho_y_q <= rho_y;
            end
        end
    end

endmodule
